// File: rtl/restoring_divider_8bit.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
// Produces one quotient bit per clock; a zero divisor finishes immediately.
module restoring_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] prem;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  // Trial subtract at WIDTH+1 bits; the borrow bit selects restore.
  always_comb begin
    shifted = {prem, work[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr};
    qbit    = ~diff[WIDTH];
    rem_nx  = qbit ? diff[WIDTH-1:0]
                   : shifted[WIDTH-1:0];
    quo_nx  = {work[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      work        <= '0;
      dvsr        <= '0;
      prem        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              work  <= dividend;
              dvsr  <= divisor;
              prem  <= '0;
              count <= '0;
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          // Quotient bits fill the working register as dividend bits leave it.
          work  <= quo_nx;
          prem  <= rem_nx;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= quo_nx;
            remainder   <= rem_nx;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
